// File: rtl/bubsys_snd_pkg.sv
// Shared types and helpers for the Bubble System stereo sound mixer.
package bubsys_snd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } mix_state_e;

    // 16 + 2*g == 2*(8 + g); 8 + g is the code with its sign bit inverted.
    function automatic logic [4:0] gain_mult(input logic [3:0] code);
        return {~code[3], code[2:0], 1'b0};
    endfunction

    function automatic int acc_width(input int iw, input int nch);
        return iw + 6 + $clog2(nch) + 1;
    endfunction

endpackage

// File: rtl/bubsys_snd_mixer_if.sv
// Bundle of the mixer's sample/control inputs and mix/status outputs.
interface bubsys_snd_mixer_if
    import bubsys_snd_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 16,
    parameter int OW  = 16,
    parameter int GW  = 4
);
    logic                sample_stb;
    logic [NCH*IW-1:0]   ch_sample;
    logic [NCH*GW-1:0]   vol;
    logic [NCH*2-1:0]    pan;
    logic signed [OW-1:0] snd_l;
    logic signed [OW-1:0] snd_r;
    logic                snd_valid;
    logic                busy;
    logic                clip_l;
    logic                clip_r;
    logic                overrun;

    modport master (
        output sample_stb, ch_sample, vol, pan,
        input  snd_l, snd_r, snd_valid, busy, clip_l, clip_r, overrun
    );

    modport slave (
        input  sample_stb, ch_sample, vol, pan,
        output snd_l, snd_r, snd_valid, busy, clip_l, clip_r, overrun
    );
endinterface

// File: rtl/bubsys_snd_mixer_sat.sv
// Signed saturator: clamps an IN_W-bit value to the OUT_W-bit signed range.
module bubsys_sat
    import bubsys_snd_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_value,
    output logic signed [OUT_W-1:0] sat_value,
    output logic                    clipped
);
    generate
        if (IN_W > OUT_W) begin : g_narrow
            logic in_range;
            // In range when every bit above the output sign bit matches it.
            assign in_range  = (&in_value[IN_W-1:OUT_W-1]) | ~(|in_value[IN_W-1:OUT_W-1]);
            assign clipped   = ~in_range;
            assign sat_value = in_range ? in_value[OUT_W-1:0]
                             : (in_value[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                 : {1'b0, {(OUT_W-1){1'b1}}});
        end else if (IN_W == OUT_W) begin : g_equal
            assign clipped   = 1'b0;
            assign sat_value = in_value;
        end else begin : g_wide
            assign clipped   = 1'b0;
            assign sat_value = {{(OUT_W-IN_W){in_value[IN_W-1]}}, in_value};
        end
    endgenerate
endmodule

// File: rtl/bubsys_snd_mixer.sv
// N-channel stereo mixer: snapshot on strobe, one-channel-per-cycle MAC, then saturate.
module bubsys_snd_mixer
    import bubsys_snd_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 16,
    parameter int OW  = 16,
    parameter int GW  = 4
) (
    input  logic                 i_EMU_CLK72M,
    input  logic                 i_EMU_SOFTRST,
    input  logic                 i_SAMPLE_STB,
    input  logic [NCH*IW-1:0]    i_CH_SAMPLE,
    input  logic [NCH*GW-1:0]    i_VOL,
    input  logic [NCH*2-1:0]     i_PAN,
    output logic signed [OW-1:0] o_SND_L,
    output logic signed [OW-1:0] o_SND_R,
    output logic                 o_SND_VALID,
    output logic                 o_BUSY,
    output logic                 o_CLIP_L,
    output logic                 o_CLIP_R,
    output logic                 o_OVERRUN
);
    localparam int ACCW = acc_width(IW, NCH);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    mix_state_e state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [NCH*IW-1:0]     samp_q, samp_d;
    logic [NCH*GW-1:0]     vol_q, vol_d;
    logic [NCH*2-1:0]      pan_q, pan_d;
    logic signed [ACCW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [OW-1:0]  snd_l_q, snd_l_d, snd_r_q, snd_r_d;
    logic                  valid_q, valid_d;
    logic                  clip_l_q, clip_l_d, clip_r_q, clip_r_d;
    logic                  overrun_q, overrun_d;

    logic signed [IW-1:0]   cur_samp;
    logic [GW-1:0]          cur_vol;
    logic [1:0]             cur_pan;
    logic signed [IW+5:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] shf_l, shf_r;
    logic signed [OW-1:0]   sat_l, sat_r;
    logic                   sat_clip_l, sat_clip_r;

    assign cur_samp = samp_q[idx_q*IW +: IW];
    assign cur_vol  = vol_q[idx_q*GW +: GW];
    assign cur_pan  = pan_q[idx_q*2 +: 2];
    assign prod     = cur_samp * $signed({1'b0, gain_mult(cur_vol)});
    assign prod_ext = {{(ACCW-IW-6){prod[IW+5]}}, prod};

    // Floor division by 16 undoes the 1/16 gain scaling before saturation.
    assign shf_l = acc_l_q >>> 4;
    assign shf_r = acc_r_q >>> 4;

    bubsys_sat #(.IN_W(ACCW), .OUT_W(OW)) u_sat_l (
        .in_value  (shf_l),
        .sat_value (sat_l),
        .clipped   (sat_clip_l)
    );

    bubsys_sat #(.IN_W(ACCW), .OUT_W(OW)) u_sat_r (
        .in_value  (shf_r),
        .sat_value (sat_r),
        .clipped   (sat_clip_r)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        samp_d    = samp_q;
        vol_d     = vol_q;
        pan_d     = pan_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        snd_l_d   = snd_l_q;
        snd_r_d   = snd_r_q;
        valid_d   = 1'b0;
        clip_l_d  = clip_l_q;
        clip_r_d  = clip_r_q;
        overrun_d = overrun_q;

        if (i_SAMPLE_STB && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (i_SAMPLE_STB) begin
                    samp_d  = i_CH_SAMPLE;
                    vol_d   = i_VOL;
                    pan_d   = i_PAN;
                    acc_l_d = '0;
                    acc_r_d = '0;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (cur_pan[0]) acc_l_d = acc_l_q + prod_ext;
                if (cur_pan[1]) acc_r_d = acc_r_q + prod_ext;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = ST_SAT;
            end
            ST_SAT: begin
                snd_l_d  = sat_l;
                snd_r_d  = sat_r;
                valid_d  = 1'b1;
                clip_l_d = clip_l_q | sat_clip_l;
                clip_r_d = clip_r_q | sat_clip_r;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_EMU_CLK72M) begin
        if (i_EMU_SOFTRST) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            samp_q    <= '0;
            vol_q     <= '0;
            pan_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            snd_l_q   <= '0;
            snd_r_q   <= '0;
            valid_q   <= 1'b0;
            clip_l_q  <= 1'b0;
            clip_r_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            samp_q    <= samp_d;
            vol_q     <= vol_d;
            pan_q     <= pan_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            snd_l_q   <= snd_l_d;
            snd_r_q   <= snd_r_d;
            valid_q   <= valid_d;
            clip_l_q  <= clip_l_d;
            clip_r_q  <= clip_r_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_SND_L     = snd_l_q;
    assign o_SND_R     = snd_r_q;
    assign o_SND_VALID = valid_q;
    assign o_BUSY      = (state_q != ST_IDLE);
    assign o_CLIP_L    = clip_l_q;
    assign o_CLIP_R    = clip_r_q;
    assign o_OVERRUN   = overrun_q;
endmodule

// File: tb/tb_bubsys_snd_mixer.sv
// Directed bench for the stereo mixer: gain, pan, saturation, overrun and reset cases.
module tb_bubsys_snd_mixer;
    localparam int NCH = 4;
    localparam int IW  = 16;
    localparam int OW  = 16;
    localparam int GW  = 4;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   miss_cnt;

    bubsys_snd_mixer_if #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW)) sif ();

    bubsys_snd_mixer #(.NCH(NCH), .IW(IW), .OW(OW), .GW(GW)) dut (
        .i_EMU_CLK72M  (clk),
        .i_EMU_SOFTRST (rst),
        .i_SAMPLE_STB  (sif.sample_stb),
        .i_CH_SAMPLE   (sif.ch_sample),
        .i_VOL         (sif.vol),
        .i_PAN         (sif.pan),
        .o_SND_L       (sif.snd_l),
        .o_SND_R       (sif.snd_r),
        .o_SND_VALID   (sif.snd_valid),
        .o_BUSY        (sif.busy),
        .o_CLIP_L      (sif.clip_l),
        .o_CLIP_R      (sif.clip_r),
        .o_OVERRUN     (sif.overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        sif.sample_stb = 1'b0;
        sif.ch_sample  = '0;
        sif.vol        = '0;
        sif.pan        = '0;
    endtask

    task automatic set_ch(input int k, input logic signed [IW-1:0] s,
                          input logic [GW-1:0] g, input logic [1:0] p);
        sif.ch_sample[k*IW +: IW] = s;
        sif.vol[k*GW +: GW]       = g;
        sif.pan[k*2 +: 2]         = p;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Strobe in cycle 0; returns the cycle index at which VALID was seen (-1 if never).
    task automatic run_mix(output int lat);
        @(negedge clk);
        sif.sample_stb = 1'b1;
        @(negedge clk);
        sif.sample_stb = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            if (sif.snd_valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({sif.snd_l, sif.snd_r, sif.snd_valid, sif.busy, sif.clip_l, sif.clip_r, sif.overrun} !== '0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got L=%0d R=%0d v=%b b=%b cl=%b cr=%b ov=%b, need all 0",
                     sif.snd_l, sif.snd_r, sif.snd_valid, sif.busy, sif.clip_l, sif.clip_r, sif.overrun);
        end
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (sif.busy !== 1'b0 || sif.snd_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reset_release: busy=%b valid=%b, need 0 0", sif.busy, sif.snd_valid);
        end
    endtask

    task automatic test_unity();
        int lat;
        clear_inputs();
        set_ch(0, 16'sd1000, 4'd0, 2'b11);
        run_mix(lat);
        vec_cnt++;
        if (lat !== NCH + 2) begin
            miss_cnt++;
            $display("FAIL unity_latency: got %0d, need %0d", lat, NCH + 2);
        end
        vec_cnt++;
        if (sif.snd_l !== 16'sd1000 || sif.snd_r !== 16'sd1000) begin
            miss_cnt++;
            $display("FAIL unity_value: got L=%0d R=%0d, need 1000 1000", sif.snd_l, sif.snd_r);
        end
        vec_cnt++;
        if (sif.clip_l !== 1'b0 || sif.clip_r !== 1'b0 || sif.busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL unity_flags: got cl=%b cr=%b busy=%b, need 0 0 0", sif.clip_l, sif.clip_r, sif.busy);
        end
        @(negedge clk);
        vec_cnt++;
        if (sif.snd_valid !== 1'b0 || sif.snd_l !== 16'sd1000) begin
            miss_cnt++;
            $display("FAIL unity_hold: got valid=%b L=%0d, need 0 1000", sif.snd_valid, sif.snd_l);
        end
    endtask

    task automatic test_gain_pan();
        int lat;
        clear_inputs();
        set_ch(0, 16'sd1000, 4'd7, 2'b01);
        run_mix(lat);
        vec_cnt++;
        if (lat !== NCH + 2 || sif.snd_l !== 16'sd1875 || sif.snd_r !== 16'sd0) begin
            miss_cnt++;
            $display("FAIL gain_max_pan_l: got lat=%0d L=%0d R=%0d, need 6 1875 0", lat, sif.snd_l, sif.snd_r);
        end
    endtask

    task automatic test_mute();
        int lat;
        clear_inputs();
        set_ch(0, -16'sd1000, 4'b1000, 2'b11);
        run_mix(lat);
        vec_cnt++;
        if (lat !== NCH + 2 || sif.snd_l !== 16'sd0 || sif.snd_r !== 16'sd0) begin
            miss_cnt++;
            $display("FAIL mute: got lat=%0d L=%0d R=%0d, need 6 0 0", lat, sif.snd_l, sif.snd_r);
        end
    endtask

    task automatic test_clip_pos();
        int lat;
        clear_inputs();
        for (int k = 0; k < NCH; k++) set_ch(k, 16'sd30000, 4'd7, 2'b11);
        run_mix(lat);
        vec_cnt++;
        if (sif.snd_l !== 16'sd32767 || sif.snd_r !== 16'sd32767) begin
            miss_cnt++;
            $display("FAIL clip_pos_value: got L=%0d R=%0d, need 32767 32767", sif.snd_l, sif.snd_r);
        end
        vec_cnt++;
        if (sif.clip_l !== 1'b1 || sif.clip_r !== 1'b1) begin
            miss_cnt++;
            $display("FAIL clip_pos_flags: got cl=%b cr=%b, need 1 1", sif.clip_l, sif.clip_r);
        end
        clear_inputs();
        set_ch(0, 16'sd1000, 4'd0, 2'b11);
        run_mix(lat);
        vec_cnt++;
        if (sif.snd_l !== 16'sd1000 || sif.clip_l !== 1'b1 || sif.clip_r !== 1'b1) begin
            miss_cnt++;
            $display("FAIL clip_sticky: got L=%0d cl=%b cr=%b, need 1000 1 1", sif.snd_l, sif.clip_l, sif.clip_r);
        end
    endtask

    task automatic test_clip_neg();
        int lat;
        do_reset();
        clear_inputs();
        for (int k = 0; k < NCH; k++) set_ch(k, -16'sd32768, 4'd0, 2'b10);
        run_mix(lat);
        vec_cnt++;
        if (sif.snd_r !== -16'sd32768 || sif.snd_l !== 16'sd0) begin
            miss_cnt++;
            $display("FAIL clip_neg_value: got L=%0d R=%0d, need 0 -32768", sif.snd_l, sif.snd_r);
        end
        vec_cnt++;
        if (sif.clip_r !== 1'b1 || sif.clip_l !== 1'b0) begin
            miss_cnt++;
            $display("FAIL clip_neg_flags: got cl=%b cr=%b, need 0 1", sif.clip_l, sif.clip_r);
        end
    endtask

    // Second strobe lands mid-mix; snapshot must also ignore input changes.
    task automatic test_back_to_back();
        int pulses;
        int vcyc;
        do_reset();
        clear_inputs();
        set_ch(0, 16'sd1000, 4'd0, 2'b11);
        pulses = 0;
        vcyc   = -1;
        @(negedge clk);
        sif.sample_stb = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            sif.sample_stb = (c == 3);
            if (c == 2) set_ch(0, 16'sd5000, 4'd7, 2'b11);
            if (c == 1) begin
                vec_cnt++;
                if (sif.busy !== 1'b1) begin
                    miss_cnt++;
                    $display("FAIL busy_rise: got %b, need 1", sif.busy);
                end
            end
            if (c == 3) begin
                vec_cnt++;
                if (sif.overrun !== 1'b0) begin
                    miss_cnt++;
                    $display("FAIL overrun_early: got %b, need 0", sif.overrun);
                end
            end
            if (sif.snd_valid) begin
                pulses++;
                vcyc = c;
                vec_cnt++;
                if (sif.snd_l !== 16'sd1000 || sif.snd_r !== 16'sd1000) begin
                    miss_cnt++;
                    $display("FAIL snapshot_value: got L=%0d R=%0d, need 1000 1000", sif.snd_l, sif.snd_r);
                end
            end
        end
        sif.sample_stb = 1'b0;
        vec_cnt++;
        if (pulses !== 1 || vcyc !== NCH + 2) begin
            miss_cnt++;
            $display("FAIL overrun_pulses: got %0d pulses at cycle %0d, need 1 at %0d", pulses, vcyc, NCH + 2);
        end
        vec_cnt++;
        if (sif.overrun !== 1'b1) begin
            miss_cnt++;
            $display("FAIL overrun_flag: got %b, need 1", sif.overrun);
        end
    endtask

    task automatic test_sat_cycle_strobe();
        do_reset();
        clear_inputs();
        set_ch(0, 16'sd200, 4'd0, 2'b01);
        @(negedge clk);
        sif.sample_stb = 1'b1;
        @(negedge clk);
        sif.sample_stb = 1'b0;
        repeat (NCH) @(negedge clk);
        sif.sample_stb = 1'b1;
        @(negedge clk);
        sif.sample_stb = 1'b0;
        vec_cnt++;
        if (sif.snd_valid !== 1'b1 || sif.overrun !== 1'b1 || sif.snd_l !== 16'sd200) begin
            miss_cnt++;
            $display("FAIL sat_cycle_strobe: got valid=%b ov=%b L=%0d, need 1 1 200",
                     sif.snd_valid, sif.overrun, sif.snd_l);
        end
        @(negedge clk);
        vec_cnt++;
        if (sif.busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL sat_cycle_ignored: busy=%b, need 0", sif.busy);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        clear_inputs();
        set_ch(0, 16'sd1000, 4'd0, 2'b11);
        run_mix(pulses);
        set_ch(0, 16'sd3000, 4'd0, 2'b11);
        @(negedge clk);
        sif.sample_stb = 1'b1;
        @(negedge clk);
        sif.sample_stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({sif.snd_l, sif.snd_r, sif.snd_valid, sif.busy, sif.clip_l, sif.clip_r, sif.overrun} !== '0) begin
            miss_cnt++;
            $display("FAIL reset_mid_outputs: got L=%0d R=%0d v=%b b=%b, need all 0",
                     sif.snd_l, sif.snd_r, sif.snd_valid, sif.busy);
        end
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sif.snd_valid || sif.busy) pulses++;
        end
        vec_cnt++;
        if (pulses !== 0) begin
            miss_cnt++;
            $display("FAIL reset_mid_no_valid: got %0d active cycles, need 0", pulses);
        end
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        rst      = 1'b1;
        clear_inputs();
        test_reset();
        test_unity();
        test_gain_pan();
        test_mute();
        test_clip_pos();
        test_clip_neg();
        test_back_to_back();
        test_sat_cycle_strobe();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, need completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bubsys_snd_mixer.md
Name: bubsys_snd_mixer

Overview:
- Parametrised N-channel stereo audio mixer for the Bubble System board.
- Generalises the fixed four-source sound sum (K5289, VLM, PSG1, PSG2) that uses 4-bit signed OSD volume codes.
- Adds per-channel pan enables, a sequential one-channel-per-cycle multiply-accumulate, output saturation with sticky clip flags, and overrun detection.
- Sits between the sound chips and the top-level AUDIO_L/AUDIO_R outputs.

Parameters:
- NCH, 4, number of input channels (1..16).
- IW, 16, signed input sample width.
- OW, 16, signed output sample width (OW <= IW+5).
- GW, 4, signed volume code width. The gain formula below is defined for GW=4 only.

Ports:
- i_EMU_CLK72M  in  1  system clock.
- i_EMU_SOFTRST  in  1  synchronous, active-high reset.
- i_SAMPLE_STB  in  1  one-cycle strobe that starts a mix.
- i_CH_SAMPLE  in  NCH*IW  signed samples; channel k at [k*IW +: IW].
- i_VOL  in  NCH*GW  signed volume codes; channel k at [k*GW +: GW].
- i_PAN  in  NCH*2  per channel, bit0 = route to L, bit1 = route to R.
- o_SND_L  out  OW  signed left mix.
- o_SND_R  out  OW  signed right mix.
- o_SND_VALID  out  1  one-cycle pulse when new outputs are presented.
- o_BUSY  out  1  high while a mix is in progress.
- o_CLIP_L  out  1  sticky: left output saturated since reset.
- o_CLIP_R  out  1  sticky: right output saturated since reset.
- o_OVERRUN  out  1  sticky: a strobe arrived while busy.

Behaviour:
- Reset (synchronous, any state): all outputs are 0, the FSM goes to IDLE, and the accumulators and channel index clear.
- Gain: code g (signed, -8..7) maps to multiplier m = 16 + 2*g, range 0..30 in units of 1/16.
  - g = -8 mutes the channel; g = 0 is unity; g = +7 gives 30/16.
- Product: sample * m, signed, IW+6 bits.
- Accumulator width: ACCW = IW + 6 + clog2(NCH) + 1. The accumulator never wraps.
- FSM states: IDLE, ACCUM, SAT.
  - IDLE, when i_SAMPLE_STB=1: snapshot i_CH_SAMPLE, i_VOL and i_PAN into registers; clear both accumulators; set index 0; go to ACCUM; o_BUSY goes to 1 on the next cycle.
  - ACCUM: each cycle add channel[index]'s product to accL if pan bit0 is set, and to accR if pan bit1 is set; index increments. After index NCH-1, go to SAT. This state lasts exactly NCH cycles.
  - SAT: shift each accumulator arithmetically right by 4 (floor), then saturate to the OW signed range [-2^(OW-1), 2^(OW-1)-1]. Register the results into o_SND_L/o_SND_R, pulse o_SND_VALID for one cycle, set o_CLIP_x if that side saturated, and go to IDLE with o_BUSY = 0.
- Latency: o_SND_VALID is asserted NCH+2 cycles after the strobe cycle (strobe in cycle 0 gives valid in cycle NCH+2).
- Hold: o_SND_L/R keep their last value between mixes.
- Throughput: at most one mix per NCH+2 cycles.
- Strobe while BUSY (ACCUM or SAT): the strobe is ignored, o_OVERRUN is set, and the current mix completes using its snapshot.
- Strobe in the same cycle the FSM returns to IDLE (the SAT cycle): this counts as busy, so the strobe is ignored and o_OVERRUN is set.
- Input changes after the snapshot have no effect on the current mix.
- Reset mid-ACCUM or mid-SAT: the mix is abandoned, no VALID pulse is produced, and outputs clear to 0.
- Sticky flags clear only on reset.

Decomposition:
- Package bubsys_snd_pkg holds:
  - the state enum (IDLE/ACCUM/SAT);
  - the function gain_mult(code) returning 5-bit unsigned 16+2*code;
  - the localparam helper for ACCW.
- One sub-module, bubsys_sat: parametrised signed saturator (IN_W, OUT_W) with outputs sat_value and clipped. It is instantiated twice, once for L and once for R.

Test Plan:
- NCH=4; ch0 = 1000, vol 0, pan 2'b11, other channels 0; strobe -> after 6 cycles VALID=1 with L = R = 1000; no clip flags.
- ch0 = 1000, vol +7, pan 2'b01 -> L = 1875 (1000*30/16), R = 0.
- ch0 = -1000, vol -8, pan 2'b11 -> L = R = 0 (mute).
- All four channels = 30000, vol +7, pan 2'b11 -> L = R = 32767, o_CLIP_L = o_CLIP_R = 1 and stay high over a following clean mix.
- All channels = -32768, vol 0, pan 2'b10 -> R = -32768 (saturated, clip R = 1), L = 0, clip L = 0.
- Strobe at cycle 0 and again at cycle 3 -> exactly one VALID pulse (at cycle 6) and o_OVERRUN = 1.
- Separately: reset asserted at cycle 2 -> no VALID pulse, all outputs 0, o_BUSY = 0 on the next cycle.
